stepper_pwm_bridge: RTL and testbench
=====================================

Name: stepper_pwm_bridge

Overview:
- Downstream stage of the stepper-motor phase sequencer.
- Converts the four 8-bit coil duty values (A, B, C, D) into four PWM gate signals for two H-bridges: coil pair A/C and coil pair B/D.
- Duty values are double-buffered and updated only at PWM period boundaries.
- Break-before-make dead time is inserted within each pair, so both legs of a pair are never high together.
- Faults are latched with a sticky flag.

Parameters:
- DUTY_W, 8, duty and PWM counter width.
- PRE_W, 8, prescaler width.
- DEAD_CYCLES, 4, clk cycles that both legs of a pair must be low before either leg may rise. Legal range 1..15.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- i_run, input, 1, enables PWM generation.
- i_duty_a, input, DUTY_W, coil A duty.
- i_duty_b, input, DUTY_W, coil B duty.
- i_duty_c, input, DUTY_W, coil C duty.
- i_duty_d, input, DUTY_W, coil D duty.
- i_prescale, input, PRE_W, PWM tick divider. Tick every i_prescale+1 clk cycles.
- i_fault, input, 1, external over-current fault. Synchronous to clk.
- i_fault_clr, input, 1, clears the latched fault.
- o_pwm, output, 4, gate drives. Bit order [0]=A, [1]=B, [2]=C, [3]=D.
- o_period_tick, output, 1, one-cycle pulse when shadow duties load at a period wrap.
- o_fault, output, 1, sticky fault flag.

Behaviour:
- Reset values:
  - o_pwm=0, o_period_tick=0, o_fault=0.
  - Prescaler count = 0, PWM count = 0, shadow duties = 0.
  - Both pair FSMs in OFF with dead counter = 0.
- Prescaler:
  - pre_cnt counts 0..i_prescale.
  - tick=1 in the cycle where pre_cnt==i_prescale; pre_cnt returns to 0 on the next edge.
  - i_prescale=0 gives a tick every cycle.
- PWM counter:
  - cnt advances on each tick over 0..254, giving a period of 255 ticks; 254 wraps to 0.
  - At the wrap edge, the shadow duties load from i_duty_* and o_period_tick pulses high for the following cycle.
- i_run=0:
  - pre_cnt and cnt are held at 0.
  - Shadows reload from the inputs every cycle; no o_period_tick is generated.
  - Raw requests are forced to 0.
  - When i_run rises, the first period uses the duties sampled on the last i_run=0 cycle.
- Raw request per channel (combinational):
  - req = i_run && (cnt < shadow).
  - Duty 0 gives a request that is always low.
  - Duty 255 gives a request that is always high.
- Pair FSM, one per pair; first leg is A or B, second leg is C or D:
  - States: OFF, ON_F, ON_S.
  - OFF: both legs low. dead_cnt increments each cycle and saturates at DEAD_CYCLES.
    - If dead_cnt==DEAD_CYCLES is registered and exactly one of the pair's requests is high, go to ON_F or ON_S at the next edge.
  - ON_F drives the first leg; ON_S drives the second leg.
    - Return to OFF at the next edge when the own request drops or the opposite request rises.
    - Entering OFF sets dead_cnt to 0.
  - Minimum both-low gap between legs of a pair is DEAD_CYCLES+1 clk cycles.
  - With the dead counter already saturated, an output follows its raw request with 1 clk latency.
- Conflict: both requests of a pair high in the same cycle is treated as a fault.
- Fault handling:
  - i_fault=1 or a conflict sets o_fault at the next edge.
  - On that same edge both FSMs are forced to OFF with dead_cnt=0, so o_pwm=0.
  - While o_fault=1, the FSMs are held in OFF. Counters keep running.
  - i_fault_clr clears o_fault only when no fault source is active in that cycle; set wins over clear.
- Reset mid-period immediately returns all state to the reset values.

Decomposition:
- Package stepper_pkg holds:
  - the pair-state enum {OFF, ON_F, ON_S};
  - DUTY_MAX = 255;
  - the PWM_PERIOD constant;
  - the channel index constants A=0, B=1, C=2, D=3.
- Sub-module stepper_bridge_pair implements the dead-time FSM and conflict detect. It is instantiated twice, once for A/C and once for B/D.

Test Plan:
- All scenarios use DEAD_CYCLES=4 and i_prescale=0.
- Reset release with i_run=0 and duty A=128 -> o_pwm stays 0.
  - Then set i_run=1 -> o_pwm[0] high for 128 consecutive cycles per 255-cycle period, rising 1 cycle after each cnt=0.
  - o_period_tick pulses once every 255 cycles.
- A=255, C=0, then at a wrap change to A=0, C=255 -> A falls 1 cycle after the wrap; C rises exactly 5 cycles after A falls; A and C never high together.
- Change duty B from 50 to 200 mid-period at cnt=100 -> the current period keeps 50-cycle width; the next period shows 200 cycles high.
- A=100 and C=100 simultaneously -> o_fault=1 one cycle later, o_pwm=0.
  - Then i_fault_clr with i_fault=0 -> o_fault=0, and A/C remain low for at least 5 cycles.
- i_prescale=3 with duty D=10 -> D high for 40 clk cycles per 1020-cycle period.
- Assert i_fault and i_fault_clr together -> o_fault stays 1.
  - Assert rst mid-period -> all outputs 0 immediately, cnt=0.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and constants for the stepper PWM bridge
//
// Purpose : pair-FSM state enum, PWM period constants and channel indices
//           used by stepper_pwm_bridge and stepper_bridge_pair.
// Ports   : none (package).
package stepper_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      ON_F = 2'd1,
      ON_S = 2'd2
   } pair_state_e;

   localparam int DUTY_MAX   = 255;
   // Counter runs 0..254, so a duty of DUTY_MAX keeps the request high.
   localparam int PWM_PERIOD = 255;

   localparam int CH_A = 0;
   localparam int CH_B = 1;
   localparam int CH_C = 2;
   localparam int CH_D = 3;

endpackage

// File: rtl/stepper_pwm_bridge_if.sv
// rtl/stepper_pwm_bridge_if.sv - control/status bundle of the stepper PWM bridge
//
// Purpose : groups run/duty/prescale/fault controls and the gate/status outputs.
// Ports   : i_run, i_duty_a..d, i_prescale, i_fault, i_fault_clr (to bridge);
//           o_pwm[3:0] ([0]=A [1]=B [2]=C [3]=D), o_period_tick, o_fault (from bridge).
//           master = sequencer side, slave = bridge side.
interface stepper_pwm_bridge_if #(
   parameter int DUTY_W = 8,
   parameter int PRE_W  = 8
);
   logic              i_run;
   logic [DUTY_W-1:0] i_duty_a;
   logic [DUTY_W-1:0] i_duty_b;
   logic [DUTY_W-1:0] i_duty_c;
   logic [DUTY_W-1:0] i_duty_d;
   logic [PRE_W-1:0]  i_prescale;
   logic              i_fault;
   logic              i_fault_clr;
   logic [3:0]        o_pwm;
   logic              o_period_tick;
   logic              o_fault;

   modport master (
      output i_run, i_duty_a, i_duty_b, i_duty_c, i_duty_d,
             i_prescale, i_fault, i_fault_clr,
      input  o_pwm, o_period_tick, o_fault
   );

   modport slave (
      input  i_run, i_duty_a, i_duty_b, i_duty_c, i_duty_d,
             i_prescale, i_fault, i_fault_clr,
      output o_pwm, o_period_tick, o_fault
   );
endinterface

// File: rtl/stepper_bridge_pair.sv
// rtl/stepper_bridge_pair.sv - break-before-make dead-time FSM for one H-bridge pair
//
// Purpose : drives at most one leg of a coil pair, enforcing DEAD_CYCLES+1 clk
//           of both-low between legs; flags simultaneous requests as a conflict.
// Ports   : clk, rst (async, active-high);
//           hold_off_i - force OFF with dead counter cleared (fault path);
//           req_f_i/req_s_i - raw requests of first/second leg;
//           leg_f_o/leg_s_o - registered gate drives; conflict_o - both requested.
module stepper_bridge_pair
   import stepper_pkg::*;
#(
   parameter int DEAD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic hold_off_i,
   input  logic req_f_i,
   input  logic req_s_i,
   output logic leg_f_o,
   output logic leg_s_o,
   output logic conflict_o
);

   localparam logic [3:0] DEAD_MAX = 4'(DEAD_CYCLES);

   pair_state_e state_q, state_d;
   logic [3:0]  dead_q, dead_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OFF;
         dead_q  <= '0;
      end else begin
         state_q <= state_d;
         dead_q  <= dead_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      if (hold_off_i) begin
         state_d = OFF;
         dead_d  = '0;
      end else begin
         unique case (state_q)
            OFF: begin
               if (dead_q != DEAD_MAX) begin
                  dead_d = dead_q + 4'd1;
               end
               // Only a single unambiguous request may turn a leg on.
               if ((dead_q == DEAD_MAX) && (req_f_i ^ req_s_i)) begin
                  state_d = req_f_i ? ON_F : ON_S;
               end
            end
            ON_F: begin
               if (!req_f_i || req_s_i) begin
                  state_d = OFF;
                  dead_d  = '0;
               end
            end
            ON_S: begin
               if (!req_s_i || req_f_i) begin
                  state_d = OFF;
                  dead_d  = '0;
               end
            end
            default: begin
               state_d = OFF;
               dead_d  = '0;
            end
         endcase
      end
   end

   assign leg_f_o    = (state_q == ON_F);
   assign leg_s_o    = (state_q == ON_S);
   assign conflict_o = req_f_i & req_s_i;

endmodule

// File: rtl/stepper_pwm_bridge.sv
// rtl/stepper_pwm_bridge.sv - four-coil PWM generator with dead time and fault latch
//
// Purpose : prescaled 255-tick PWM counter, period-boundary duty shadows,
//           two dead-time pairs (A/C, B/D) and a sticky fault flag.
// Ports   : clk, rst (async, active-high);
//           bus (slave) - i_run, i_duty_a..d, i_prescale, i_fault, i_fault_clr in;
//                         o_pwm, o_period_tick, o_fault out.
module stepper_pwm_bridge
   import stepper_pkg::*;
#(
   parameter int DUTY_W      = 8,
   parameter int PRE_W       = 8,
   parameter int DEAD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   stepper_pwm_bridge_if.slave  bus
);

   logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
   logic [DUTY_W-1:0]      cnt_q, cnt_d;
   logic [3:0][DUTY_W-1:0] shadow_q, shadow_d;
   logic                   period_tick_q, period_tick_d;
   logic                   fault_q, fault_d;

   logic       tick;
   logic       wrap;
   logic [3:0] req;
   logic [3:0] pwm;
   logic       conflict_ac;
   logic       conflict_bd;
   logic       fault_src;
   logic       hold_off;

   assign tick      = bus.i_run && (pre_cnt_q == bus.i_prescale);
   assign wrap      = tick && (cnt_q == DUTY_W'(PWM_PERIOD - 1));
   assign fault_src = bus.i_fault | conflict_ac | conflict_bd;
   // Held off on the setting edge and for as long as the flag stays latched.
   assign hold_off  = fault_src | fault_q;

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      if (!bus.i_run) begin
         pre_cnt_d = '0;
         cnt_d     = '0;
      end else if (tick) begin
         pre_cnt_d = '0;
         cnt_d     = wrap ? '0 : cnt_q + DUTY_W'(1);
      end else begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
      // Stopped: track inputs so the first period after run uses the latest duties.
      if (!bus.i_run || wrap) begin
         shadow_d[CH_A] = bus.i_duty_a;
         shadow_d[CH_B] = bus.i_duty_b;
         shadow_d[CH_C] = bus.i_duty_c;
         shadow_d[CH_D] = bus.i_duty_d;
      end
      period_tick_d = wrap;
      // Set wins over clear.
      fault_d = fault_src | (fault_q & ~bus.i_fault_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q     <= '0;
         cnt_q         <= '0;
         shadow_q      <= '0;
         period_tick_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         period_tick_q <= period_tick_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      req = '0;
      for (int i = 0; i < 4; i++) begin
         req[i] = bus.i_run && (cnt_q < shadow_q[i]);
      end
   end

   stepper_bridge_pair #(.DEAD_CYCLES(DEAD_CYCLES)) u_pair_ac (
      .clk        (clk),
      .rst        (rst),
      .hold_off_i (hold_off),
      .req_f_i    (req[CH_A]),
      .req_s_i    (req[CH_C]),
      .leg_f_o    (pwm[CH_A]),
      .leg_s_o    (pwm[CH_C]),
      .conflict_o (conflict_ac)
   );

   stepper_bridge_pair #(.DEAD_CYCLES(DEAD_CYCLES)) u_pair_bd (
      .clk        (clk),
      .rst        (rst),
      .hold_off_i (hold_off),
      .req_f_i    (req[CH_B]),
      .req_s_i    (req[CH_D]),
      .leg_f_o    (pwm[CH_B]),
      .leg_s_o    (pwm[CH_D]),
      .conflict_o (conflict_bd)
   );

   assign bus.o_pwm         = pwm;
   assign bus.o_period_tick = period_tick_q;
   assign bus.o_fault       = fault_q;

endmodule

// File: tb/tb_stepper_pwm_bridge.sv
// tb/tb_stepper_pwm_bridge.sv - directed self-checking bench for stepper_pwm_bridge
module tb_stepper_pwm_bridge;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   stepper_pwm_bridge_if #(.DUTY_W(8), .PRE_W(8)) bus ();

   stepper_pwm_bridge #(.DUTY_W(8), .PRE_W(8), .DEAD_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until the cycle in which o_period_tick is high.
   task automatic wait_period(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         step();
         if (bus.o_period_tick) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.o_pwm !== 4'b0 || bus.o_fault !== 1'b0 || bus.o_period_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: pwm=%b fault=%b tick=%b expected 0/0/0",
                  bus.o_pwm, bus.o_fault, bus.o_period_tick);
      end
      bus.i_duty_a = 8'd128;
      rst = 1'b0;
      repeat (10) step();
      checks++;
      if (bus.o_pwm !== 4'b0 || bus.o_period_tick !== 1'b0 || dut.cnt_q !== 8'd0) begin
         errors++;
         $display("FAIL idle_run0: pwm=%b tick=%b cnt=%0d expected 0/0/0",
                  bus.o_pwm, bus.o_period_tick, dut.cnt_q);
      end
   endtask

   task automatic test_run_duty();
      int highs = 0;
      int ticks = 0;
      int first_tick = -1;
      logic [4:0] smp;
      bus.i_run = 1'b1;
      for (int k = 0; k <= 510; k++) begin
         if (k < 255) highs += int'(bus.o_pwm[0]);
         if (k == 0)   smp[0] = bus.o_pwm[0];
         if (k == 1)   smp[1] = bus.o_pwm[0];
         if (k == 128) smp[2] = bus.o_pwm[0];
         if (k == 129) smp[3] = bus.o_pwm[0];
         if (k == 256) smp[4] = bus.o_pwm[0];
         if (bus.o_period_tick) begin
            ticks++;
            if (first_tick < 0) first_tick = k;
         end
         step();
      end
      checks++;
      if (highs != 128) begin
         errors++;
         $display("FAIL duty128_width: got %0d high cycles expected 128", highs);
      end
      checks++;
      if (smp !== 5'b10110) begin
         errors++;
         $display("FAIL duty128_edges: samples(256,129,128,1,0)=%b expected 10110", smp);
      end
      checks++;
      if (first_tick != 255 || ticks != 2) begin
         errors++;
         $display("FAIL period_tick: first=%0d count=%0d expected 255/2", first_tick, ticks);
      end
   endtask

   task automatic test_dead_time();
      bit ok;
      int low_a = 0;
      int both = 0;
      int gap_bad = 0;
      logic [3:0] pw [0:10];
      bus.i_duty_a = 8'd255;
      bus.i_duty_c = 8'd0;
      wait_period(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL dead_wait1: no period tick got 0 expected 1");
      end
      bus.i_duty_a = 8'd0;
      bus.i_duty_c = 8'd255;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         step();
         if (!bus.o_pwm[0]) low_a++;
         if (bus.o_pwm[0] && bus.o_pwm[2]) both++;
         if (bus.o_period_tick) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || low_a != 0) begin
         errors++;
         $display("FAIL duty255_full: tick_found=%0d low_cycles=%0d expected 1/0", ok, low_a);
      end
      for (int k = 0; k <= 10; k++) begin
         pw[k] = bus.o_pwm;
         if (bus.o_pwm[0] && bus.o_pwm[2]) both++;
         step();
      end
      for (int k = 1; k <= 5; k++) begin
         if (pw[k] !== 4'b0000) gap_bad++;
      end
      checks++;
      if (pw[0][0] !== 1'b1 || pw[1][0] !== 1'b0) begin
         errors++;
         $display("FAIL a_fall: a@wrap=%b a@wrap+1=%b expected 1/0", pw[0][0], pw[1][0]);
      end
      checks++;
      if (gap_bad != 0 || pw[6][2] !== 1'b1) begin
         errors++;
         $display("FAIL dead_gap: nonzero_in_gap=%0d c@wrap+6=%b expected 0/1", gap_bad, pw[6][2]);
      end
      checks++;
      if (both != 0) begin
         errors++;
         $display("FAIL ac_overlap: got %0d overlapping cycles expected 0", both);
      end
   endtask

   task automatic test_mid_period_update();
      bit ok;
      int w1 = 0;
      int w2 = 0;
      bus.i_duty_b = 8'd50;
      wait_period(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midupd_wait: no period tick got 0 expected 1");
      end
      for (int k = 0; k <= 509; k++) begin
         if (k < 255) w1 += int'(bus.o_pwm[1]);
         else         w2 += int'(bus.o_pwm[1]);
         if (k == 100) bus.i_duty_b = 8'd200;
         step();
      end
      checks++;
      if (w1 != 50 || w2 != 200) begin
         errors++;
         $display("FAIL mid_period_b: got %0d/%0d high cycles expected 50/200", w1, w2);
      end
   endtask

   task automatic test_conflict_fault();
      bit ok;
      int nonzero = 0;
      bus.i_duty_a = 8'd100;
      bus.i_duty_c = 8'd100;
      wait_period(ok);
      checks++;
      if (!ok || bus.o_fault !== 1'b0) begin
         errors++;
         $display("FAIL conflict_pre: tick_found=%0d fault=%b expected 1/0", ok, bus.o_fault);
      end
      step();
      checks++;
      if (bus.o_fault !== 1'b1 || bus.o_pwm !== 4'b0) begin
         errors++;
         $display("FAIL conflict_set: fault=%b pwm=%b expected 1/0000", bus.o_fault, bus.o_pwm);
      end
      repeat (3) step();
      bus.i_run = 1'b0;
      bus.i_duty_c = 8'd0;
      repeat (3) step();
      checks++;
      if (bus.o_fault !== 1'b1 || bus.o_pwm !== 4'b0) begin
         errors++;
         $display("FAIL fault_sticky: fault=%b pwm=%b expected 1/0000", bus.o_fault, bus.o_pwm);
      end
      bus.i_run = 1'b1;
      bus.i_fault_clr = 1'b1;
      step();
      bus.i_fault_clr = 1'b0;
      checks++;
      if (bus.o_fault !== 1'b0) begin
         errors++;
         $display("FAIL fault_clear: got %b expected 0", bus.o_fault);
      end
      for (int j = 0; j < 5; j++) begin
         if (bus.o_pwm !== 4'b0) nonzero++;
         step();
      end
      checks++;
      if (nonzero != 0 || bus.o_pwm !== 4'b0011) begin
         errors++;
         $display("FAIL post_clear_dead: early_cycles=%0d pwm@5=%b expected 0/0011",
                  nonzero, bus.o_pwm);
      end
   endtask

   task automatic test_prescale();
      int highs = 0;
      int first_tick = -1;
      logic [3:0] smp;
      bus.i_run = 1'b0;
      bus.i_duty_a = 8'd0;
      bus.i_duty_b = 8'd0;
      bus.i_duty_c = 8'd0;
      bus.i_duty_d = 8'd10;
      bus.i_prescale = 8'd3;
      repeat (10) step();
      checks++;
      if (bus.o_pwm !== 4'b0) begin
         errors++;
         $display("FAIL run0_forced_low: got %b expected 0000", bus.o_pwm);
      end
      bus.i_run = 1'b1;
      for (int k = 0; k <= 1021; k++) begin
         if (k < 1020) highs += int'(bus.o_pwm[3]);
         if (k == 0)  smp[0] = bus.o_pwm[3];
         if (k == 1)  smp[1] = bus.o_pwm[3];
         if (k == 40) smp[2] = bus.o_pwm[3];
         if (k == 41) smp[3] = bus.o_pwm[3];
         if (bus.o_period_tick && first_tick < 0) first_tick = k;
         step();
      end
      checks++;
      if (highs != 40 || smp !== 4'b0110) begin
         errors++;
         $display("FAIL prescale_d: high=%0d samples(41,40,1,0)=%b expected 40/0110", highs, smp);
      end
      checks++;
      if (first_tick != 1020) begin
         errors++;
         $display("FAIL prescale_period: first tick at %0d expected 1020", first_tick);
      end
   endtask

   task automatic test_fault_priority_and_reset();
      bus.i_fault = 1'b1;
      step();
      bus.i_fault_clr = 1'b1;
      step();
      checks++;
      if (bus.o_fault !== 1'b1 || bus.o_pwm !== 4'b0) begin
         errors++;
         $display("FAIL set_over_clear: fault=%b pwm=%b expected 1/0000", bus.o_fault, bus.o_pwm);
      end
      bus.i_fault = 1'b0;
      step();
      bus.i_fault_clr = 1'b0;
      bus.i_run = 1'b0;
      bus.i_duty_d = 8'd200;
      bus.i_prescale = 8'd0;
      repeat (8) step();
      bus.i_run = 1'b1;
      repeat (20) step();
      checks++;
      if (bus.o_pwm !== 4'b1000 || bus.o_fault !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_run: pwm=%b fault=%b expected 1000/0", bus.o_pwm, bus.o_fault);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.o_pwm !== 4'b0 || bus.o_fault !== 1'b0 || bus.o_period_tick !== 1'b0 ||
          dut.cnt_q !== 8'd0 || dut.pre_cnt_q !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: pwm=%b fault=%b tick=%b cnt=%0d pre=%0d expected all 0",
                  bus.o_pwm, bus.o_fault, bus.o_period_tick, dut.cnt_q, dut.pre_cnt_q);
      end
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.i_run       = 1'b0;
      bus.i_duty_a    = 8'd0;
      bus.i_duty_b    = 8'd0;
      bus.i_duty_c    = 8'd0;
      bus.i_duty_d    = 8'd0;
      bus.i_prescale  = 8'd0;
      bus.i_fault     = 1'b0;
      bus.i_fault_clr = 1'b0;
      test_reset();
      test_run_duty();
      test_dead_time();
      test_mid_period_update();
      test_conflict_fault();
      test_prescale();
      test_fault_priority_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
